// File: rtl/fp_arb_wire.sv
// Shared types for the floating-point issue arbiter.
//   NREQ_MAX          largest supported requester count
//   fp_arb_state_t    arbiter FSM states
//   fp_arb_resp_type  registered response (result + NV,DZ,OF,UF,NX flags)
//   fp_exe_in_type    fp_unit request bundle; 'enable' is the one-cycle issue strobe
package fp_arb_wire;

  localparam int unsigned NREQ_MAX = 8;

  typedef enum logic [1:0] {
    FP_ARB_IDLE,
    FP_ARB_ISSUE,
    FP_ARB_BUSY,
    FP_ARB_RESP
  } fp_arb_state_t;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
  } fp_arb_resp_type;

  typedef struct packed {
    logic [63:0] data1;
    logic [63:0] data2;
    logic [63:0] data3;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [4:0]  op;
    logic        enable;
  } fp_exe_in_type;

endpackage

// File: rtl/fp_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        request vector
//   ptr        index of the last grant; search starts at ptr+1 (mod NREQ)
//   grant      one-hot grant (zero when no request)
//   grant_idx  index of the granted requester
//   grant_any  at least one request present
module fp_rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    grant_any
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IW'((32'(ptr) + k) % NREQ);
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fp_issue_arbiter.sv
// Shares one fp_unit between NREQ requesters with round-robin arbitration.
// One operation in flight: accept, issue a one-cycle enable pulse, wait for
// fpu_ready, then hold the response for the owning requester.
// Optional feature: define FP_ARB_TIMEOUT_EN to enable a BUSY watchdog of
// TIMEOUT cycles that pulses timeout_err and returns flags 5'b10000.
// Ports:
//   clock, reset              clock; synchronous active-low reset
//   req_valid/req_ready/req_op  per-requester request handshake and operands
//   resp_valid/resp_ready       per-requester response handshake
//   resp_result/resp_flags      shared response payload (valid with resp_valid)
//   flush                       discard the in-flight operation
//   fpu_i                       to fp_unit, enable = issue pulse
//   fpu_result/flags/ready      from fp_unit
//   timeout_err                 one-cycle watchdog pulse
module fp_issue_arbiter
  import fp_arb_wire::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic          [NREQ-1:0] req_valid,
  output logic          [NREQ-1:0] req_ready,
  input  fp_exe_in_type [NREQ-1:0] req_op,
  output logic          [NREQ-1:0] resp_valid,
  input  logic          [NREQ-1:0] resp_ready,
  output logic          [63:0]     resp_result,
  output logic          [4:0]      resp_flags,
  input  logic                     flush,
  output fp_exe_in_type            fpu_i,
  input  logic          [63:0]     fpu_result,
  input  logic          [4:0]      fpu_flags,
  input  logic                     fpu_ready,
  output logic                     timeout_err
);

  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > NREQ_MAX || TIMEOUT < 2) begin : g_param_check
    $error("fp_issue_arbiter: NREQ must be 2..%0d and TIMEOUT at least 2", NREQ_MAX);
  end

  fp_arb_state_t   state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic            drop;
  fp_arb_resp_type resp_q;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;

  fp_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready   = (reset && state == FP_ARB_IDLE) ? grant : '0;
  assign resp_result = resp_q.result;
  assign resp_flags  = resp_q.flags;

`ifdef FP_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;
`else
  assign timeout_err = 1'b0;
`endif

  // fpu_i doubles as the latched op register; its enable field is the issue pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= FP_ARB_IDLE;
      rr_ptr     <= IW'(NREQ - 1);
      owner      <= '0;
      drop       <= 1'b0;
      fpu_i      <= '0;
      resp_q     <= '0;
      resp_valid <= '0;
`ifdef FP_ARB_TIMEOUT_EN
      cnt         <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef FP_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        FP_ARB_IDLE: begin
          if (grant_any) begin
            fpu_i        <= req_op[grant_idx];
            fpu_i.enable <= 1'b1;
            owner        <= grant_idx;
            rr_ptr       <= grant_idx;
            state        <= FP_ARB_ISSUE;
          end
        end
        FP_ARB_ISSUE: begin
          fpu_i.enable <= 1'b0;
          if (flush) drop <= 1'b1;
`ifdef FP_ARB_TIMEOUT_EN
          cnt <= '0;
`endif
          state <= FP_ARB_BUSY;
        end
        FP_ARB_BUSY: begin
          // A flush arriving together with fpu_ready already drops that result.
          if (fpu_ready) begin
            if (drop || flush) begin
              drop  <= 1'b0;
              state <= FP_ARB_IDLE;
            end else begin
              resp_q            <= '{result: fpu_result, flags: fpu_flags};
              resp_valid[owner] <= 1'b1;
              state             <= FP_ARB_RESP;
            end
          end
`ifdef FP_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            if (drop || flush) begin
              drop  <= 1'b0;
              state <= FP_ARB_IDLE;
            end else begin
              resp_q            <= '{result: 64'h0, flags: 5'b10000};
              resp_valid[owner] <= 1'b1;
              state             <= FP_ARB_RESP;
            end
          end
`endif
          else if (flush) begin
            drop <= 1'b1;
          end
`ifdef FP_ARB_TIMEOUT_EN
          cnt <= cnt + CW'(1);
`endif
        end
        FP_ARB_RESP: begin
          if (flush || resp_ready[owner]) begin
            resp_valid <= '0;
            state      <= FP_ARB_IDLE;
          end
        end
        default: state <= FP_ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_issue_arbiter.sv
// Directed self-checking bench for fp_issue_arbiter (NREQ=2, TIMEOUT=16).
// The bench plays the role of fp_unit, returning hand-computed IEEE results.
module tb_fp_issue_arbiter;
  import fp_arb_wire::*;

  localparam int unsigned NREQ = 2;
  localparam logic [4:0] OP_FADD = 5'd0;
  localparam logic [4:0] OP_FMUL = 5'd2;
  localparam logic [4:0] OP_FDIV = 5'd3;

  logic                     clock = 1'b0;
  logic                     reset;
  logic          [NREQ-1:0] req_valid;
  logic          [NREQ-1:0] req_ready;
  fp_exe_in_type [NREQ-1:0] req_op;
  logic          [NREQ-1:0] resp_valid;
  logic          [NREQ-1:0] resp_ready;
  logic          [63:0]     resp_result;
  logic          [4:0]      resp_flags;
  logic                     flush;
  fp_exe_in_type            fpu_i;
  logic          [63:0]     fpu_result;
  logic          [4:0]      fpu_flags;
  logic                     fpu_ready;
  logic                     timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  fp_issue_arbiter #(.NREQ(NREQ), .TIMEOUT(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_flags  (resp_flags),
    .flush       (flush),
    .fpu_i       (fpu_i),
    .fpu_result  (fpu_result),
    .fpu_flags   (fpu_flags),
    .fpu_ready   (fpu_ready),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic fp_exe_in_type mk_op(input logic [63:0] a, input logic [63:0] b, input logic [4:0] op);
    fp_exe_in_type o;
    o        = '0;
    o.data1  = a;
    o.data2  = b;
    o.op     = op;
    o.enable = 1'b0;
    return o;
  endfunction

  task automatic test_reset();
    reset = 1'b0; req_valid = 2'b11; resp_ready = 2'b00; flush = 1'b0;
    fpu_ready = 1'b0; fpu_result = 64'hDEAD_BEEF_0000_0001; fpu_flags = 5'b11111;
    req_op[0] = mk_op(64'h3F800000, 64'h40000000, OP_FADD);
    req_op[1] = mk_op(64'h40000000, 64'h40400000, OP_FMUL);
    tick(); tick();
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_checks++; if (fpu_i !== '0) begin n_fail++; $display("FAIL reset_fpu_i: got %h want 0", fpu_i); end
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
    n_checks++; if (resp_result !== 64'h0 || resp_flags !== 5'b0) begin n_fail++; $display("FAIL reset_resp_data: got %h/%b want 0/0", resp_result, resp_flags); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    req_valid = 2'b00;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_fadd();
    fp_exe_in_type op, exp_i;
    op = mk_op(64'h3F800000, 64'h40000000, OP_FADD);
    req_op[0] = op; req_valid = 2'b01; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_req_ready: got %b want 01", req_ready); end
    n_checks++; if (fpu_i.enable !== 1'b0) begin n_fail++; $display("FAIL single_idle_enable: got %b want 0", fpu_i.enable); end
    tick(); req_valid = 2'b00; #1;
    exp_i = op; exp_i.enable = 1'b1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL single_issue_req_ready: got %b want 00", req_ready); end
    n_checks++; if (fpu_i !== exp_i) begin n_fail++; $display("FAIL single_issue_fpu_i: got %h want %h", fpu_i, exp_i); end
    tick();
    n_checks++; if (fpu_i.enable !== 1'b0) begin n_fail++; $display("FAIL single_busy_enable: got %b want 0", fpu_i.enable); end
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL single_busy_resp_valid: got %b want 00", resp_valid); end
    fpu_ready = 1'b1; fpu_result = 64'h40400000; fpu_flags = 5'b00000;
    tick();
    fpu_ready = 1'b0; fpu_result = 64'hBAD0_BAD0_BAD0_BAD0; fpu_flags = 5'b11111; #1;
    n_checks++; if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL single_resp_valid: got %b want 01", resp_valid); end
    n_checks++; if (resp_result !== 64'h40400000) begin n_fail++; $display("FAIL single_resp_result: got %h want 40400000", resp_result); end
    n_checks++; if (resp_flags !== 5'b00000) begin n_fail++; $display("FAIL single_resp_flags: got %b want 00000", resp_flags); end
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL single_resp_done: got %b want 00", resp_valid); end
  endtask

  // Pointer is 0 after the single op, so the alternation starts at requester 1.
  task automatic test_back_to_back();
    logic [63:0] exp_d1 [2];
    logic [63:0] exp_res [2];
    int          exp_g [4];
    logic [1:0]  oh;
    exp_g = '{1, 0, 1, 0};
    exp_d1[0] = 64'h3F800000; exp_res[0] = 64'h40000000;
    exp_d1[1] = 64'h40000000; exp_res[1] = 64'h40C00000;
    req_op[0] = mk_op(64'h3F800000, 64'h3F800000, OP_FADD);
    req_op[1] = mk_op(64'h40000000, 64'h40400000, OP_FMUL);
    req_valid = 2'b11; #1;
    for (int i = 0; i < 4; i++) begin
      oh = 2'b01 << exp_g[i];
      n_checks++; if (req_ready !== oh) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %b want %b", i, req_ready, oh); end
      tick();
      n_checks++; if (fpu_i.enable !== 1'b1 || fpu_i.data1 !== exp_d1[exp_g[i]]) begin n_fail++; $display("FAIL b2b_issue[%0d]: got en=%b d1=%h want en=1 d1=%h", i, fpu_i.enable, fpu_i.data1, exp_d1[exp_g[i]]); end
      tick();
      fpu_ready = 1'b1; fpu_result = exp_res[exp_g[i]]; fpu_flags = 5'b00000;
      tick();
      fpu_ready = 1'b0;
      n_checks++; if (resp_valid !== oh || resp_result !== exp_res[exp_g[i]]) begin n_fail++; $display("FAIL b2b_resp[%0d]: got v=%b r=%h want v=%b r=%h", i, resp_valid, resp_result, oh, exp_res[exp_g[i]]); end
      resp_ready = 2'b11;
      tick();
      resp_ready = 2'b00;
      n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL b2b_resp_done[%0d]: got %b want 00", i, resp_valid); end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_resp_hold();
    req_op[1] = mk_op(64'h3F800000, 64'h40400000, OP_FDIV);
    req_valid = 2'b11; #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL hold_grant: got %b want 10", req_ready); end
    tick();
    tick();
    fpu_ready = 1'b1; fpu_result = 64'h3EAAAAAB; fpu_flags = 5'b00001;
    tick();
    fpu_ready = 1'b0;
    resp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      fpu_ready = (i == 2); fpu_result = 64'hBAD; fpu_flags = 5'b10101; #1;
      n_checks++; if (resp_valid !== 2'b10 || resp_result !== 64'h3EAAAAAB || resp_flags !== 5'b00001) begin n_fail++; $display("FAIL hold_resp[%0d]: got v=%b r=%h f=%b want v=10 r=3eaaaaab f=00001", i, resp_valid, resp_result, resp_flags); end
      n_checks++; if (req_ready !== 2'b00 || fpu_i.enable !== 1'b0) begin n_fail++; $display("FAIL hold_quiet[%0d]: got rdy=%b en=%b want 00/0", i, req_ready, fpu_i.enable); end
      tick();
    end
    fpu_ready = 1'b0;
    resp_ready = 2'b10;
    tick();
    resp_ready = 2'b00;
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL hold_done: got %b want 00", resp_valid); end
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL hold_next_grant: got %b want 01", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_flush();
    req_op[0] = mk_op(64'h40000000, 64'h40400000, OP_FDIV);
    req_op[1] = mk_op(64'h3F800000, 64'h40400000, OP_FDIV);
    req_valid = 2'b01; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL flush_grant0: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b10; #1;
    n_checks++; if (fpu_i.enable !== 1'b1 || req_ready !== 2'b00) begin n_fail++; $display("FAIL flush_issue: got en=%b rdy=%b want 1/00", fpu_i.enable, req_ready); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (resp_valid !== 2'b00 || req_ready !== 2'b00) begin n_fail++; $display("FAIL flush_busy[%0d]: got v=%b rdy=%b want 00/00", i, resp_valid, req_ready); end
      tick();
    end
    fpu_ready = 1'b1; fpu_result = 64'h3F2AAAAB; fpu_flags = 5'b00001;
    tick();
    fpu_ready = 1'b0;
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL flush_dropped: got %b want 00", resp_valid); end
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL flush_next_grant: got %b want 10", req_ready); end
    flush = 1'b1;
    tick();
    flush = 1'b0; req_valid = 2'b00;
    n_checks++; if (fpu_i.enable !== 1'b1 || fpu_i.data1 !== 64'h3F800000) begin n_fail++; $display("FAIL flush_idle_issue: got en=%b d1=%h want 1/3f800000", fpu_i.enable, fpu_i.data1); end
    tick();
    fpu_ready = 1'b1; fpu_result = 64'h3EAAAAAB; fpu_flags = 5'b00001;
    tick();
    fpu_ready = 1'b0;
    n_checks++; if (resp_valid !== 2'b10 || resp_result !== 64'h3EAAAAAB) begin n_fail++; $display("FAIL flush_idle_resp: got v=%b r=%h want 10/3eaaaaab", resp_valid, resp_result); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL flush_resp_clear: got %b want 00", resp_valid); end
    req_valid = 2'b01; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL flush_resp_idle: got %b want 01", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid_op();
    req_op[0] = mk_op(64'h3F800000, 64'h3F800000, OP_FADD);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    reset = 1'b0; req_valid = 2'b11;
    tick();
    n_checks++; if (fpu_i !== '0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_mid_issue: got fpu_i=%h rdy=%b want 0/00", fpu_i, req_ready); end
    n_checks++; if (resp_valid !== 2'b00 || resp_result !== 64'h0 || resp_flags !== 5'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_resp: got v=%b r=%h f=%b t=%b want 00/0/0/0", resp_valid, resp_result, resp_flags, timeout_err); end
    reset = 1'b1; req_valid = 2'b00;
    fpu_ready = 1'b1; fpu_result = 64'h40000000; fpu_flags = 5'b0;
    tick();
    fpu_ready = 1'b0;
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_mid_stale_ready: got %b want 00", resp_valid); end
    req_valid = 2'b11; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_mid_rr_ptr: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    n_checks++; if (fpu_i.enable !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reissue: got %b want 1", fpu_i.enable); end
    tick();
    fpu_ready = 1'b1; fpu_result = 64'h40000000; fpu_flags = 5'b00000;
    tick();
    fpu_ready = 1'b0;
    n_checks++; if (resp_valid !== 2'b01 || resp_result !== 64'h40000000) begin n_fail++; $display("FAIL rst_mid_resp_after: got v=%b r=%h want 01/40000000", resp_valid, resp_result); end
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
  endtask

  task automatic test_timeout();
    req_op[1] = mk_op(64'h3F800000, 64'h40400000, OP_FDIV);
    req_valid = 2'b10; #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL to_grant: got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    for (int i = 0; i < 15; i++) begin
      n_checks++; if (timeout_err !== 1'b0 || resp_valid !== 2'b00) begin n_fail++; $display("FAIL to_busy[%0d]: got t=%b v=%b want 0/00", i, timeout_err, resp_valid); end
      tick();
    end
`ifdef FP_ARB_TIMEOUT_EN
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_last_busy: got %b want 0", timeout_err); end
    tick();
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got %b want 1", timeout_err); end
    n_checks++; if (resp_valid !== 2'b10 || resp_result !== 64'h0 || resp_flags !== 5'b10000) begin n_fail++; $display("FAIL to_resp: got v=%b r=%h f=%b want 10/0/10000", resp_valid, resp_result, resp_flags); end
    fpu_ready = 1'b1; fpu_result = 64'h3EAAAAAB; fpu_flags = 5'b00001;
    tick();
    fpu_ready = 1'b0;
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %b want 0", timeout_err); end
    n_checks++; if (resp_valid !== 2'b10 || resp_result !== 64'h0 || resp_flags !== 5'b10000) begin n_fail++; $display("FAIL to_late_ready: got v=%b r=%h f=%b want 10/0/10000", resp_valid, resp_result, resp_flags); end
`else
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (timeout_err !== 1'b0 || resp_valid !== 2'b00) begin n_fail++; $display("FAIL to_wait[%0d]: got t=%b v=%b want 0/00", i, timeout_err, resp_valid); end
    end
    fpu_ready = 1'b1; fpu_result = 64'h3EAAAAAB; fpu_flags = 5'b00001;
    tick();
    fpu_ready = 1'b0;
    n_checks++; if (resp_valid !== 2'b10 || resp_result !== 64'h3EAAAAAB || resp_flags !== 5'b00001) begin n_fail++; $display("FAIL to_slow_resp: got v=%b r=%h f=%b want 10/3eaaaaab/00001", resp_valid, resp_result, resp_flags); end
`endif
    resp_ready = 2'b10;
    tick();
    resp_ready = 2'b00;
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL to_done: got %b want 00", resp_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single_fadd();
    test_back_to_back();
    test_resp_hold();
    test_flush();
    test_reset_mid_op();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
